plic_claim_arbiter: RTL

Claim/complete engine for the platform-level interrupt controller. It latches source requests into pending bits and scans them sequentially against the per-source priorities and the enable/threshold masks from the enable-register block. It holds the winning interrupt ID for the core and handles the claim-read and complete-write handshake on the claim/complete register. It sits between the interrupt sources, the enable/priority register blocks and the core's external-interrupt input.

---
 rtl/plic_claim_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/plic_claim_arbiter.sv
// plic_claim_arbiter: PLIC claim/complete engine.
// Gateways latch source requests into pending bits; a sequential sweep picks
// the highest-priority pending, unmasked source (ties to the lowest ID) and
// presents its ID on the claim/complete register.
// Build option: define PLIC_EDGE_TRIGGER_EN for edge-triggered gateways
// (pending sets on a 0->1 request transition); default is level-triggered.
module plic_claim_arbiter #(
  parameter int unsigned N_interrupts = 32
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [N_interrupts-1:0]    interrupt_requests,
  input  logic [N_interrupts*32-1:0] interrupt_priority_regs,
  input  logic [N_interrupts-1:0]    interrupt_masks,
  input  logic [31:0]                claim_complete_addr,
  input  logic [31:0]                addr,
  input  logic                       ren,
  input  logic                       wen,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       addr_valid,
  output logic [N_interrupts-1:0]    interrupt_pending,
  output logic                       interrupt_service_request
);

  localparam int unsigned IDX_W = (N_interrupts > 1) ? $clog2(N_interrupts) : 1;
  localparam int unsigned ID_W  = $clog2(N_interrupts + 1);

  typedef enum logic {SCAN, LOAD} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ID_W-1:0]         best_id_q, best_id_d;
  logic [31:0]             best_prio_q, best_prio_d;
  logic [ID_W-1:0]         claim_id_q, claim_id_d;
  logic [N_interrupts-1:0] pending_q, pending_d;
  logic [N_interrupts-1:0] in_service_q, in_service_d;
  logic                    isr_q, isr_d;
  logic [N_interrupts-1:0] req_fire;

  logic [31:0]      addr_off;
  logic [IDX_W-1:0] claim_idx;
  logic [IDX_W-1:0] complete_idx;
  logic             claim_hit;
  logic             complete_hit;
  logic [31:0]      cand_prio;

`ifdef PLIC_EDGE_TRIGGER_EN
  logic [N_interrupts-1:0] req_prev_q, req_prev_d;

  // Edge gateway: a request fires only on its rising transition
  always_comb begin
    req_prev_d = interrupt_requests;
    req_fire   = interrupt_requests & ~req_prev_q;
  end

  // Previous request register for edge detection
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) req_prev_q <= '0;
    else        req_prev_q <= req_prev_d;
  end
`else
  // Level gateway: an active request fires every cycle
  always_comb begin
    req_fire = interrupt_requests;
  end
`endif

  // Claim/complete register decode and claim read data
  always_comb begin
    addr_off     = addr - claim_complete_addr;
    addr_valid   = (addr_off < 32'd4);
    claim_idx    = IDX_W'(claim_id_q - ID_W'(1));
    claim_hit    = addr_valid & ren & (claim_id_q != '0) &
                   pending_q[claim_idx] & ~interrupt_masks[claim_idx];
    rdata        = claim_hit ? 32'(claim_id_q) : '0;
    complete_hit = addr_valid & wen & (wdata >= 32'd1) &
                   (wdata <= 32'(N_interrupts));
    complete_idx = IDX_W'(wdata - 32'd1);
  end

  // Gateway pending/in-service update; a claim overrides a same-cycle request
  always_comb begin
    pending_d    = pending_q | (req_fire & ~in_service_q & ~pending_q);
    in_service_d = in_service_q;
    if (complete_hit) in_service_d[complete_idx] = 1'b0;
    if (claim_hit) begin
      pending_d[claim_idx]    = 1'b0;
      in_service_d[claim_idx] = 1'b1;
    end
  end

  // Sweep FSM: one source per SCAN cycle, LOAD publishes the winner
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    best_id_d   = best_id_q;
    best_prio_d = best_prio_q;
    claim_id_d  = claim_id_q;
    isr_d       = (claim_id_q != '0);
    cand_prio   = interrupt_priority_regs[32*int'(idx_q) +: 32];
    case (state_q)
      SCAN: begin
        if (pending_q[idx_q] && !interrupt_masks[idx_q] && (cand_prio > best_prio_q)) begin
          best_id_d   = ID_W'(idx_q) + ID_W'(1);
          best_prio_d = cand_prio;
        end
        if (idx_q == IDX_W'(N_interrupts - 1)) state_d = LOAD;
        else                                   idx_d   = idx_q + 1'b1;
      end
      LOAD: begin
        claim_id_d  = best_id_q;
        best_id_d   = '0;
        best_prio_d = '0;
        idx_d       = '0;
        state_d     = SCAN;
      end
      default: state_d = SCAN;
    endcase
    // A successful claim invalidates the sweep in progress
    if (claim_hit) begin
      claim_id_d  = '0;
      best_id_d   = '0;
      best_prio_d = '0;
      idx_d       = '0;
      state_d     = SCAN;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= SCAN;
      idx_q        <= '0;
      best_id_q    <= '0;
      best_prio_q  <= '0;
      claim_id_q   <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      isr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_id_q    <= best_id_d;
      best_prio_q  <= best_prio_d;
      claim_id_q   <= claim_id_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      isr_q        <= isr_d;
    end
  end

  assign interrupt_pending         = pending_q;
  assign interrupt_service_request = isr_q;

endmodule
